// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the nibble-serial adder.
//   stateT   - sequencer state (IDLE, RUN, DONE)
//   NIBBLE_W - width of the adder slice in bits
package adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice.
//   a4, b4 - nibble operands
//   cin    - carry in
//   s4     - nibble sum
//   cout   - carry out of bit 3
module cla4_slice
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s4,
  output logic                cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g = a4 & b4;
    p = a4 ^ b4;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s4 = p ^ c[3:0];
    cout = c[4];
  end
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/subtract over one 4-bit CLA slice, LSB nibble first.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid, in_ready   - operand handshake (a, b, sub sampled on accept)
//   out_valid, out_ready - result handshake
//   sum, carry_out       - result and carry out of the MSB (for sub: 1 = no borrow)
//   overflow             - signed two's-complement overflow
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CNT_W = $clog2(NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  stateT state, nextState;
  logic [WIDTH-1:0] aReg, bReg, sumReg;
  logic [CNT_W-1:0] cnt;
  logic carryReg, carryOutReg, overflowReg, last;
  logic [NIBBLE_W-1:0] sliceA, sliceB, sliceS;
  logic sliceC;

  always_comb begin
    last = cnt == LAST;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    nextState = state == IDLE ? (in_valid ? RUN : IDLE)
              : state == RUN  ? (last ? DONE : RUN)
              : (out_ready ? IDLE : DONE);
    sliceA = aReg[NIBBLE_W*cnt +: NIBBLE_W];
    sliceB = bReg[NIBBLE_W*cnt +: NIBBLE_W];
  end

  cla4_slice slice (
    .a4(sliceA),
    .b4(sliceB),
    .cin(carryReg),
    .s4(sliceS),
    .cout(sliceC)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;

  // Subtraction is A + ~B + 1: B is inverted on capture and the +1 enters as the first carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg <= '0;
      bReg <= '0;
      sumReg <= '0;
      cnt <= '0;
      carryReg <= 1'b0;
      carryOutReg <= 1'b0;
      overflowReg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      aReg <= a;
      bReg <= sub ? ~b : b;
      carryReg <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      sumReg[NIBBLE_W*cnt +: NIBBLE_W] <= sliceS;
      carryReg <= sliceC;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        carryOutReg <= sliceC;
        overflowReg <= (aReg[WIDTH-1] == bReg[WIDTH-1]) && (sliceS[NIBBLE_W-1] != aReg[WIDTH-1]);
      end
    end
  end

  assign sum = sumReg;
  assign carry_out = carryOutReg;
  assign overflow = overflowReg;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: vector, corner-case and random checks of the nibble-serial adder.
module tb_nibble_serial_adder_ctrl;
  localparam int W = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic sub;
    logic [W-1:0] s;
    logic co;
    logic ov;
  } vecT;

  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, carry_out, overflow;
  logic [W-1:0] sum;
  int errors = 0, checks = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       output logic [W-1:0] s, output logic co, output logic ov);
    int sa, sb, r;
    logic [W:0] wide;
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    r = ts ? sa - sb : sa + sb;
    wide = {1'b0, ta} + {1'b0, tb};
    s = ts ? ta - tb : ta + tb;
    co = ts ? (ta >= tb) : wide[W];
    ov = (r < -(2 ** (W - 1))) || (r > 2 ** (W - 1) - 1);
  endtask

  task automatic startOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_valid = 1;
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic waitDone(output int lat);
    for (lat = 0; lat < 50; lat++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL done_timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic finishOp;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  task automatic runCheck(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic [W-1:0] es, input logic eco, input logic eov);
    int lat;
    startOp(ta, tb, ts);
    waitDone(lat);
    check({tag, "_latency"}, W'(lat), W'(NIB));
    check({tag, "_sum"}, sum, es);
    check({tag, "_carry"}, W'(carry_out), W'(eco));
    check({tag, "_ovf"}, W'(overflow), W'(eov));
    check({tag, "_inready_done"}, W'(in_ready), '0);
    finishOp();
    @(negedge clk);
    check({tag, "_idle_valid"}, W'(out_valid), '0);
    check({tag, "_idle_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    vecT vecs[5];
    logic [W-1:0] s0, ms;
    logic mco, mov;
    int lat;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    #1 rst_n = 0;
    #2;
    check("rst_inready", W'(in_ready), W'(1));
    check("rst_outvalid", W'(out_valid), '0);
    check("rst_sum", sum, '0);
    check("rst_carry", W'(carry_out), '0);
    check("rst_ovf", W'(overflow), '0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) runCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                               vecs[i].s, vecs[i].co, vecs[i].ov);

    // Back-pressure: result held while out_ready is low, a competing request is ignored.
    startOp(16'h1111, 16'h2222, 1'b0);
    waitDone(lat);
    s0 = sum;
    check("bp_sum", s0, 16'h3333);
    a = 16'h0F0F; b = 16'h0101; sub = 0; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", W'(out_valid), W'(1));
      check("bp_hold_ready", W'(in_ready), '0);
      check("bp_hold_sum", sum, s0);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    check("bp_idle_ready", W'(in_ready), W'(1));
    check("bp_idle_valid", W'(out_valid), '0);
    @(posedge clk);
    #1 in_valid = 0;
    waitDone(lat);
    check("bp_second_latency", W'(lat), W'(NIB));
    check("bp_second_sum", sum, 16'h1010);
    finishOp();

    // Reset during RUN discards the partial result immediately.
    startOp(16'hABCD, 16'h1234, 1'b0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_outvalid", W'(out_valid), '0);
    check("mid_rst_inready", W'(in_ready), W'(1));
    check("mid_rst_sum", sum, '0);
    check("mid_rst_carry", W'(carry_out), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", W'(out_valid), '0);
    end
    rst_n = 1;
    runCheck("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, ms, mco, mov);
      startOp(ra, rb, rs);
      waitDone(lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("rnd_sum", sum, ms);
      check("rnd_carry", W'(carry_out), W'(mco));
      check("rnd_ovf", W'(overflow), W'(mov));
      finishOp();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead adder slice over WIDTH/4 nibbles, LSB nibble first, with a registered carry between nibbles. It trades area for latency in datapaths that need wide adds at low throughput. Valid/ready handshake on both the operand and result sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8
NIB (localparam), WIDTH/4, nibble count = RUN-phase cycle count
CNT_W (localparam), $clog2(NIB), nibble index width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  1 = A-B, 0 = A+B; sampled with operands
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry_out  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, nibble counter=0, carry reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch a into A_reg; latch b (inverted if sub) into B_reg; carry reg <- sub; counter <- 0; go RUN.
- RUN: in_ready=0. Each cycle the slice adds nibble[counter] of A_reg and B_reg with carry reg; write 4-bit sum into sum[4*counter +: 4]; carry reg <- slice carry; counter++. On the cycle with counter==NIB-1: also set carry_out = slice carry, compute overflow = (A_reg[WIDTH-1]==B_reg[WIDTH-1]) && (new sum[WIDTH-1] != A_reg[WIDTH-1]), go DONE.
- DONE: out_valid=1; sum/carry_out/overflow stable. On out_ready: out_valid <- 0, go IDLE. in_ready stays 0 in DONE (no overlap).
- Latency: operands accepted at edge 0 -> out_valid high after edge NIB (5 edges... i.e. visible in cycle NIB+1 for WIDTH=16: RUN cycles 1..4, out_valid from cycle 5). Throughput: one op per NIB+2 cycles minimum.
- Width rules: all arithmetic modulo 2^WIDTH; B inversion is bitwise over WIDTH; carry-in 1 completes two's complement.
- sum is updated nibble-by-nibble during RUN; consumers must read only while out_valid=1.
- out_ready held low: remain in DONE indefinitely, outputs unchanged.
- in_valid while not IDLE: ignored (no latch); requester must hold until in_ready.
- Reset mid-RUN or mid-DONE: immediate return to reset values, partial result discarded, no out_valid pulse.
- Slice: sum4 = a4 ^ b4 ^ c, with full lookahead carries c[i+1]=g[i] | p[i]&c[i] expanded; carry out = c[4] (true carry out of bit 3, not bit 2).

Decomposition:
- Shared package adder_pkg: state enum type (IDLE/RUN/DONE), localparam NIBBLE_W=4.
- One sub-module: cla4_slice (combinational 4-bit CLA: a4, b4, cin -> s4, cout), instantiated once.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, sub=0, accepted cycle 0 -> out_valid first high cycle 5, sum=0x5555, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry_out=1, overflow=0 (ripple across all nibbles).
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, carry_out=0, overflow=1; a=0x8000,b=0x0001,sub=1 -> sum=0x7FFF, carry_out=1, overflow=1.
- a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry_out=0 (borrow), overflow=0.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, second in_valid not taken; out_ready=1 -> IDLE next cycle, then second op accepted.
- Drive rst_n low during RUN cycle 2 -> all outputs at reset values immediately; after release, new op 0x0001+0x0001 -> sum=0x0002; random 1000-op compare against A±B reference model.
